alu_pipe: RTL and testbench
===========================

// Module: alu_pipe
// PURPOSE
// Parametrised, registered successor to the combinational ARM7 ALU. It executes one op per accepted request behind valid/ready handshakes.
// It keeps an architectural NZCV flag register, so ADC/SBC use the real carry, and adds an iterative multi-cycle MUL.
// It sits between the decode/operand-fetch stage and register writeback in the ARM7 datapath.
// PARAMETERS
// WIDTH    32  operand/result width in bits (>=8)
// SHAMT_W  8   shift-amount field width, taken from b[SHAMT_W-1:0]
// PORTS
// clk         in   1        rising-edge clock
// rst_n       in   1        asynchronous active-low reset
// in_valid    in   1        request valid
// in_ready    out  1        request accepted when in_valid && in_ready at a clk edge
// opcode      in   4        operation, encoding below
// a, b        in   WIDTH    operands
// set_flags   in   1        1 = update NZCV from this op (CMP always updates)
// out_valid   out  1        result valid
// out_ready   in   1        consumer takes result when out_valid && out_ready
// result      out  WIDTH    registered result
// out_err     out  1        result is from an invalid opcode
// flags       out  4        architectural {N,Z,C,V}
// BEHAVIOUR
// Reset (async, rst_n=0): state=IDLE, out_valid=0, result=0, out_err=0, flags=4'b0000, in_ready=0 while rst_n=0.
//   In-flight MUL is abandoned; nothing is emitted after reset is released.
// FSM states: IDLE, MUL.
//   IDLE->MUL when a MUL request is accepted.
//   MUL->IDLE after WIDTH iterations, result loaded into the output register.
// in_ready = (state==IDLE) && (!out_valid || out_ready): single output register, throughput 1 op/clk for non-MUL ops.
// Latency: non-MUL op accepted at edge k -> out_valid=1 after edge k; MUL accepted at edge k -> out_valid=1 after edge k+WIDTH.
// Output register holds result/out_err/out_valid stable while out_valid && !out_ready.
//   out_valid clears on a take with no new completion the same edge.
// Opcodes:
//   0000 ADD a+b; 0001 SUB a-b; 0010 AND; 0011 ORR; 0100 EOR; 0101 MUL (low WIDTH bits of a*b, unsigned shift-add)
//   0110 ADC a+b+C; 0111 SBC a-b-!C; 1000 LSL; 1001 LSR; 1010 ASR; 1011 MVN ~a
//   1100 CMP: result=a-b, flags always written
//   1101-1111 invalid: result=0, out_err=1, flags unchanged
// ADC/SBC C is the flags register value at the accepting edge. The flag write of the previous op, accepted 1 clk earlier, is already visible (no hazard).
// Arithmetic flags (ADD/SUB/ADC/SBC/CMP): computed in WIDTH+1 bits.
//   N=result[WIDTH-1]; Z=(result==0)
//   C=carry out; for subtract C=NOT borrow (a>=b unsigned for SUB/CMP)
//   V=signed overflow
// Logical/MVN/MUL: update N,Z only; C,V unchanged.
// Shifts: s=b[SHAMT_W-1:0]. s=0 -> result=a, C unchanged.
//   1<=s<=WIDTH: C=last bit shifted out.
//   s>WIDTH: LSL/LSR result=0, C=0; ASR result={WIDTH{a[WIDTH-1]}}, C=a[WIDTH-1].
//   N,Z updated; V unchanged.
// Flags are written at the same edge the result loads into the output register (MUL: at completion).
// set_flags=0 leaves flags untouched (except CMP).
// in_valid while in_ready=0 is ignored; the requester must hold the request.
// TESTING (WIDTH=32)
// 1. Reset mid-MUL (a=7,b=9, rst_n low at cycle 5) -> out_valid stays 0, flags=0; next ADD 1+1 -> result=2 one clk after accept.
// 2. ADD 0xFFFFFFFF+1, set_flags=1 -> result=0, NZCV=0110; then ADC 0+0 -> result=1. SUB 5-7 -> 0xFFFFFFFE, NZCV=1000.
// 3. ADD 0x7FFFFFFF+1 set_flags -> 0x80000000, NZCV=1001; CMP 3,3 with set_flags=0 -> NZCV=0110.
// 4. MUL 0x10000*0x10001 -> result=0x00010000 exactly 32 clks after accept; in_ready=0 throughout.
// 5. Shifts: LSL 0x80000001 by 1 -> 0x2, C=1; ASR 0x80000000 by 40 -> 0xFFFFFFFF, C=1; LSR by 0 -> a, C unchanged.
// 6. Back-pressure: out_ready=0 for 3 clks with stream ADD/EOR -> first result held stable, in_ready=0, no loss or duplication; opcode 1110 -> out_err=1, result=0.

Source files
------------

// File: rtl/alu_pipe.sv
// Registered ARM7-style ALU with an architectural NZCV register and an iterative shift-add MUL.
// Requests and results use valid/ready handshakes around a single output register.
module alu_pipe #(
  parameter int WIDTH   = 32,
  parameter int SHAMT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             set_flags,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             out_err,
  output logic [3:0]       flags
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_ORR = 4'h3,
                         OP_EOR = 4'h4, OP_MUL = 4'h5, OP_ADC = 4'h6, OP_SBC = 4'h7,
                         OP_LSL = 4'h8, OP_LSR = 4'h9, OP_ASR = 4'hA, OP_MVN = 4'hB,
                         OP_CMP = 4'hC;
  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic {ST_IDLE, ST_MUL} state_t;

  state_t             state;
  logic [CNT_W-1:0]   mul_cnt;
  logic               mul_sf;
  logic [WIDTH-1:0]   mul_acc_p1, mul_mcand_p1, mul_mplier_p1, mul_add;

  logic               accept, take;
  logic [WIDTH-1:0]   alu_res, arith_b;
  logic               alu_err, wr_flags, carry_in;
  logic [3:0]         nxt_flags;
  logic [WIDTH:0]     sum_w, lsl_w, lsr_w;
  logic signed [WIDTH:0] asr_w;
  logic [SHAMT_W-1:0] shamt;

  // N and Z from a result, C and V carried through
  function automatic logic [3:0] nz_upd(input logic [3:0] f, input logic [WIDTH-1:0] r);
    return {r[WIDTH-1], (r == '0), f[1:0]};
  endfunction

  function automatic logic [3:0] shift_flags(input logic [3:0] f, input logic [WIDTH-1:0] r,
                                             input logic c, input logic [SHAMT_W-1:0] s);
    return {r[WIDTH-1], (r == '0), ((s == '0) ? f[1] : c), f[0]};
  endfunction

  assign in_ready = rst_n && (state == ST_IDLE) && (!out_valid || out_ready);
  assign accept   = in_valid && in_ready;
  assign take     = out_valid && out_ready;
  assign mul_add  = mul_mplier_p1[0] ? (mul_acc_p1 + mul_mcand_p1) : mul_acc_p1;

  // Stage 0: single-cycle operations evaluated from the request
  always_comb begin
    arith_b  = b;
    carry_in = 1'b0;
    case (opcode)
      OP_SUB, OP_CMP: begin arith_b = ~b; carry_in = 1'b1;     end
      OP_ADC:         begin arith_b = b;  carry_in = flags[1]; end
      OP_SBC:         begin arith_b = ~b; carry_in = flags[1]; end
      default:        ;
    endcase
    sum_w = {1'b0, a} + {1'b0, arith_b} + {{WIDTH{1'b0}}, carry_in};
    shamt = b[SHAMT_W-1:0];
    lsl_w = {1'b0, a} << shamt;
    lsr_w = {a, 1'b0} >> shamt;
    asr_w = $signed({a, 1'b0}) >>> shamt;

    alu_res   = '0;
    alu_err   = 1'b0;
    wr_flags  = set_flags;
    nxt_flags = flags;
    case (opcode)
      OP_ADD, OP_SUB, OP_ADC, OP_SBC, OP_CMP: begin
        alu_res   = sum_w[WIDTH-1:0];
        nxt_flags = {sum_w[WIDTH-1], (sum_w[WIDTH-1:0] == '0), sum_w[WIDTH],
                     (a[WIDTH-1] == arith_b[WIDTH-1]) && (sum_w[WIDTH-1] != a[WIDTH-1])};
        if (opcode == OP_CMP) wr_flags = 1'b1;
      end
      OP_AND: begin alu_res = a & b; nxt_flags = nz_upd(flags, alu_res); end
      OP_ORR: begin alu_res = a | b; nxt_flags = nz_upd(flags, alu_res); end
      OP_EOR: begin alu_res = a ^ b; nxt_flags = nz_upd(flags, alu_res); end
      OP_MVN: begin alu_res = ~a;    nxt_flags = nz_upd(flags, alu_res); end
      OP_LSL: begin
        alu_res   = lsl_w[WIDTH-1:0];
        nxt_flags = shift_flags(flags, alu_res, lsl_w[WIDTH], shamt);
      end
      OP_LSR: begin
        alu_res   = lsr_w[WIDTH:1];
        nxt_flags = shift_flags(flags, alu_res, lsr_w[0], shamt);
      end
      OP_ASR: begin
        alu_res   = asr_w[WIDTH:1];
        nxt_flags = shift_flags(flags, alu_res, asr_w[0], shamt);
      end
      default: begin
        alu_err  = 1'b1;
        wr_flags = 1'b0;
      end
    endcase
  end

  // Stage 1: multiplier datapath, one partial product per clock
  always_ff @(posedge clk) begin
    if (accept && (opcode == OP_MUL)) begin
      mul_acc_p1    <= '0;
      mul_mcand_p1  <= a;
      mul_mplier_p1 <= b;
    end else if (state == ST_MUL) begin
      mul_acc_p1    <= mul_add;
      mul_mcand_p1  <= mul_mcand_p1 << 1;
      mul_mplier_p1 <= mul_mplier_p1 >> 1;
    end
  end

  // Stage 1: output register, flags and sequencing
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      mul_cnt   <= '0;
      mul_sf    <= 1'b0;
      out_valid <= 1'b0;
      result    <= '0;
      out_err   <= 1'b0;
      flags     <= 4'b0000;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept && (opcode == OP_MUL)) begin
            state   <= ST_MUL;
            mul_cnt <= '0;
            mul_sf  <= set_flags;
            if (take) out_valid <= 1'b0;
          end else if (accept) begin
            result    <= alu_res;
            out_err   <= alu_err;
            out_valid <= 1'b1;
            if (wr_flags) flags <= nxt_flags;
          end else if (take) begin
            out_valid <= 1'b0;
          end
        end
        ST_MUL: begin
          if (mul_cnt == CNT_W'(WIDTH - 1)) begin
            state     <= ST_IDLE;
            result    <= mul_add;
            out_err   <= 1'b0;
            out_valid <= 1'b1;
            if (mul_sf) flags <= nz_upd(flags, mul_add);
          end else begin
            mul_cnt <= mul_cnt + 1'b1;
            if (take) out_valid <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed-vector bench for alu_pipe at WIDTH=32: flag chaining, shifts, MUL latency,
// reset during MUL and output back-pressure.
module tb_alu_pipe;
  localparam int W = 32;

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   opcode = 4'h0;
  logic [W-1:0] a = '0, b = '0;
  logic         set_flags = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic [W-1:0] result;
  logic         out_err;
  logic [3:0]   flags;

  int nvec  = 0;
  int nfail = 0;

  alu_pipe #(.WIDTH(W), .SHAMT_W(8)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .a(a), .b(b), .set_flags(set_flags),
    .out_valid(out_valid), .out_ready(out_ready), .result(result),
    .out_err(out_err), .flags(flags)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]   op;
    logic [W-1:0] a, b;
    logic         sf;
    logic [W-1:0] res;
    logic         err;
    logic [3:0]   fl;
    int           lat;
  } vec_t;

  vec_t tbl[$];

  task automatic add_vec(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                         input logic sf, input logic [W-1:0] res, input logic err,
                         input logic [3:0] fl);
    vec_t v;
    v.op = op; v.a = va; v.b = vb; v.sf = sf; v.res = res; v.err = err; v.fl = fl;
    v.lat = (op == 4'h5) ? W + 1 : 1;
    tbl.push_back(v);
  endtask

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Presents a request and returns #1 after the edge that accepts it
  task automatic issue(input logic [3:0] op, input logic [W-1:0] va, input logic [W-1:0] vb,
                       input logic sf);
    int guard;
    @(negedge clk);
    opcode = op; a = va; b = vb; set_flags = sf; in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("issue_timeout", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  // Waits for out_valid, returning the number of falling edges seen since acceptance
  task automatic wait_result(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 100);
  endtask

  initial begin
    int  n;
    logic bad;

    // reset state
    #12;
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_result", result, 32'd0);
    chk("rst_out_err", 32'(out_err), 32'd0);
    chk("rst_flags", 32'(flags), 32'd0);
    @(negedge clk) rst_n = 1'b1;

    // reset in the middle of a multiply
    issue(4'h0, 32'hFFFF_FFFF, 32'd1, 1'b1);
    wait_result(n);
    chk("pre_flags", 32'(flags), 32'h6);
    issue(4'h5, 32'd7, 32'd9, 1'b1);
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("midmul_out_valid", 32'(out_valid), 32'd0);
    chk("midmul_flags", 32'(flags), 32'd0);
    chk("midmul_in_ready", 32'(in_ready), 32'd0);
    @(negedge clk) rst_n = 1'b1;
    bad = 1'b0;
    repeat (40) begin
      @(negedge clk);
      if (out_valid) bad = 1'b1;
    end
    chk("post_rst_no_emit", 32'(bad), 32'd0);
    issue(4'h0, 32'd1, 32'd1, 1'b0);
    @(negedge clk);
    chk("post_rst_add_valid", 32'(out_valid), 32'd1);
    chk("post_rst_add_result", result, 32'd2);
    chk("post_rst_flags", 32'(flags), 32'd0);

    // vector table; flags chain from one row to the next, starting from 0000
    add_vec(4'h0, 32'hFFFF_FFFF, 32'd1,        1, 32'h0000_0000, 0, 4'b0110);
    add_vec(4'h6, 32'd0,         32'd0,        1, 32'h0000_0001, 0, 4'b0000);
    add_vec(4'h1, 32'd5,         32'd7,        1, 32'hFFFF_FFFE, 0, 4'b1000);
    add_vec(4'h0, 32'h7FFF_FFFF, 32'd1,        1, 32'h8000_0000, 0, 4'b1001);
    add_vec(4'hC, 32'd3,         32'd3,        0, 32'h0000_0000, 0, 4'b0110);
    add_vec(4'h7, 32'd10,        32'd3,        1, 32'h0000_0007, 0, 4'b0010);
    add_vec(4'h1, 32'd3,         32'd5,        1, 32'hFFFF_FFFE, 0, 4'b1000);
    add_vec(4'h7, 32'd10,        32'd3,        1, 32'h0000_0006, 0, 4'b0010);
    add_vec(4'h2, 32'hF0F0_F0F0, 32'hFF00_FF00, 1, 32'hF000_F000, 0, 4'b1010);
    add_vec(4'h3, 32'd0,         32'd0,        1, 32'h0000_0000, 0, 4'b0110);
    add_vec(4'h4, 32'hAAAA_5555, 32'hFFFF_0000, 0, 32'h5555_5555, 0, 4'b0110);
    add_vec(4'hB, 32'd0,         32'd0,        1, 32'hFFFF_FFFF, 0, 4'b1010);
    add_vec(4'h8, 32'h8000_0001, 32'd1,        1, 32'h0000_0002, 0, 4'b0010);
    add_vec(4'hA, 32'h8000_0000, 32'd40,       1, 32'hFFFF_FFFF, 0, 4'b1010);
    add_vec(4'h9, 32'h1234_5678, 32'd0,        1, 32'h1234_5678, 0, 4'b0010);
    add_vec(4'h9, 32'h0000_0002, 32'd1,        1, 32'h0000_0001, 0, 4'b0000);
    add_vec(4'h8, 32'h0000_0001, 32'd32,       1, 32'h0000_0000, 0, 4'b0110);
    add_vec(4'h9, 32'hFFFF_FFFF, 32'd33,       1, 32'h0000_0000, 0, 4'b0100);
    add_vec(4'h6, 32'd1,         32'd1,        1, 32'h0000_0002, 0, 4'b0000);
    add_vec(4'hA, 32'h8000_0010, 32'd4,        1, 32'hF800_0001, 0, 4'b1000);
    add_vec(4'hE, 32'd5,         32'd5,        1, 32'h0000_0000, 1, 4'b1000);
    add_vec(4'hD, 32'd5,         32'd5,        1, 32'h0000_0000, 1, 4'b1000);
    add_vec(4'h1, 32'h8000_0000, 32'd1,        1, 32'h7FFF_FFFF, 0, 4'b0011);
    add_vec(4'h5, 32'h0001_0000, 32'h0001_0001, 1, 32'h0001_0000, 0, 4'b0011);
    add_vec(4'h5, 32'd7,         32'd9,        0, 32'h0000_003F, 0, 4'b0011);

    foreach (tbl[i]) begin
      issue(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sf);
      wait_result(n);
      chk($sformatf("v%0d_latency", i), 32'(n), 32'(tbl[i].lat));
      chk($sformatf("v%0d_result", i), result, tbl[i].res);
      chk($sformatf("v%0d_err", i), 32'(out_err), 32'(tbl[i].err));
      chk($sformatf("v%0d_flags", i), 32'(flags), 32'(tbl[i].fl));
    end

    // MUL: in_ready low for the whole iteration, result exactly WIDTH clocks after accept
    issue(4'h5, 32'h0001_0000, 32'h0001_0001, 1'b0);
    bad = 1'b0;
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      if (out_valid || in_ready) bad = 1'b1;
    end
    chk("mul_busy", 32'(bad), 32'd0);
    @(negedge clk);
    chk("mul_done_valid", 32'(out_valid), 32'd1);
    chk("mul_done_result", result, 32'h0001_0000);

    // back-pressure: ADD held while out_ready=0, queued EOR follows exactly once
    @(negedge clk);
    out_ready = 1'b0;
    opcode = 4'h0; a = 32'd10; b = 32'd20; set_flags = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    opcode = 4'h4; a = 32'h0000_00F0; b = 32'h0000_00FF;
    bad = 1'b0;
    for (int k = 0; k < 3; k++) begin
      if (k > 0) @(negedge clk);
      if (!out_valid || result !== 32'd30 || in_ready || out_err) bad = 1'b1;
    end
    chk("bp_hold", 32'(bad), 32'd0);
    out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    chk("bp_second_valid", 32'(out_valid), 32'd1);
    chk("bp_second_result", result, 32'h0000_000F);
    @(negedge clk);
    chk("bp_no_dup", 32'(out_valid), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end
endmodule
